// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: sequences the single Regfile access slot between buffered
// writeback writes and operand-fetch reads, returning both operands through a
// valid/ready response.
// Build option: RF_ARB_FWD_EN enables forwarding from the write FIFO and the
// starve counter. Without it, reads wait for the FIFO to drain.
module rf_port_arbiter #(
    parameter int WBUF_DEPTH_LOG2 = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [4:0]               wr_addr,
    input  logic [31:0]              wr_data,
    input  logic                     rd_valid,
    output logic                     rd_ready,
    input  logic [4:0]               rd_addr1,
    input  logic [4:0]               rd_addr2,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data1,
    output logic [31:0]              rsp_data2,
    output logic                     rf_RegWrite,
    output logic [4:0]               rf_A1,
    output logic [4:0]               rf_A2,
    output logic [4:0]               rf_A3,
    output logic [31:0]              rf_WD3,
    input  logic [31:0]              rf_RD1,
    input  logic [31:0]              rf_RD2,
    output logic [WBUF_DEPTH_LOG2:0] wbuf_count
);
    localparam int DEPTH = 1 << WBUF_DEPTH_LOG2;
    localparam int SW    = $clog2(STARVE_LIMIT + 2);
    localparam logic [WBUF_DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [WBUF_DEPTH_LOG2:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_e;
    state_e state_q, state_d;

    logic [4:0]                 wb_addr_q [DEPTH];
    logic [31:0]                wb_data_q [DEPTH];
    logic [WBUF_DEPTH_LOG2-1:0] head_q, tail_q;
    logic [WBUF_DEPTH_LOG2:0]   count_q, count_d;
    logic [4:0]                 a1_q, a2_q;
    logic [31:0]                rsp1_q, rsp2_q, rsp1_d, rsp2_d;
    logic [SW-1:0]              starve;
    logic full, empty, push, pop, force_wr, rd_gate, rd_open, rd_fire;

    assign full       = (count_q == (WBUF_DEPTH_LOG2+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign wr_ready   = !full;
    // Writes to r0 are acknowledged but never reach the FIFO.
    assign push       = wr_valid && !full && (wr_addr != 5'd0);
    assign force_wr   = full || (starve == SW'(STARVE_LIMIT));
    assign rd_open    = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    assign rd_ready   = rd_open && !force_wr && rd_gate;
    assign rd_fire    = rd_valid && rd_ready;
    // A read owns the slot; otherwise the FIFO head drains into the Regfile.
    assign pop        = !rd_fire && !empty;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_data1  = rsp1_q;
    assign rsp_data2  = rsp2_q;
    assign wbuf_count = count_q;

    assign rf_RegWrite = pop;
    assign rf_A3       = wb_addr_q[head_q];
    assign rf_WD3      = wb_data_q[head_q];
    // Read addresses hold between reads so idle-slot refreshes keep RD stable.
    assign rf_A1       = rd_fire ? rd_addr1 : a1_q;
    assign rf_A2       = rd_fire ? rd_addr2 : a2_q;

`ifdef RF_ARB_FWD_EN
    logic [SW-1:0]              starve_q;
    logic                       hit1_d, hit2_d, hit1_q, hit2_q;
    logic [31:0]                fwd1_d, fwd2_d, fwd1_q, fwd2_q;
    logic [WBUF_DEPTH_LOG2-1:0] idx;

    assign starve  = starve_q;
    assign rd_gate = 1'b1;

    // Scan head to tail so the youngest matching entry wins.
    always_comb begin
        hit1_d = 1'b0;
        hit2_d = 1'b0;
        fwd1_d = '0;
        fwd2_d = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + WBUF_DEPTH_LOG2'(i);
            if ((WBUF_DEPTH_LOG2+1)'(i) < count_q) begin
                if (wb_addr_q[idx] == rd_addr1) begin
                    hit1_d = 1'b1;
                    fwd1_d = wb_data_q[idx];
                end
                if (wb_addr_q[idx] == rd_addr2) begin
                    hit2_d = 1'b1;
                    fwd2_d = wb_data_q[idx];
                end
            end
        end
    end

    // Forwarding capture at acceptance and the read-starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit1_q   <= 1'b0;
            hit2_q   <= 1'b0;
            fwd1_q   <= '0;
            fwd2_q   <= '0;
            starve_q <= '0;
        end else begin
            if (rd_fire) begin
                hit1_q <= hit1_d;
                hit2_q <= hit2_d;
                fwd1_q <= fwd1_d;
                fwd2_q <= fwd2_d;
            end
            if (pop)
                starve_q <= '0;
            else if (rd_fire && !empty && (starve_q != SW'(STARVE_LIMIT)))
                starve_q <= starve_q + SW'(1);
        end
    end
`else
    assign starve  = '0;
    assign rd_gate = empty;
`endif

    // Response value: forwarded data over Regfile data, r0 always zero.
    always_comb begin
        rsp1_d = rf_RD1;
        rsp2_d = rf_RD2;
`ifdef RF_ARB_FWD_EN
        if (hit1_q) rsp1_d = fwd1_q;
        if (hit2_q) rsp2_d = fwd2_q;
`endif
        if (a1_q == 5'd0) rsp1_d = '0;
        if (a2_q == 5'd0) rsp2_d = '0;
    end

    // FIFO occupancy next-state.
    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (!push && pop) count_d = count_q - CNT_ONE;
    end

    // Read sequencing FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_fire) state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready) state_d = rd_fire ? CAPTURE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care while pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[tail_q] <= wr_addr;
            wb_data_q[tail_q] <= wr_data;
        end
    end

    // Control state, read addresses and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            rsp1_q  <= '0;
            rsp2_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) tail_q <= tail_q + PTR_ONE;
            if (pop)  head_q <= head_q + PTR_ONE;
            if (rd_fire) begin
                a1_q <= rd_addr1;
                a2_q <= rd_addr2;
            end
            if (state_q == CAPTURE) begin
                rsp1_q <= rsp1_d;
                rsp2_q <= rsp2_d;
            end
        end
    end
endmodule

// File: tb/tb_rf_port_arbiter.sv
// Testbench for rf_port_arbiter with a behavioural Regfile and a response
// scoreboard fed at read acceptance.
module tb_rf_port_arbiter;
    localparam int DEPTH = 4;
    localparam int SL    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0, rd_valid = 1'b0, rsp_ready = 1'b1;
    logic [4:0]  wr_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
    logic [31:0] wr_data = '0;
    logic        wr_ready, rd_ready, rsp_valid, rf_RegWrite;
    logic [31:0] rsp_data1, rsp_data2, rf_WD3;
    logic [31:0] rf_RD1 = '0, rf_RD2 = '0;
    logic [4:0]  rf_A1, rf_A2, rf_A3;
    logic [2:0]  wbuf_count;

    int checks = 0, failures = 0, cyc = 0, nopop = 0;
    int fire_cnt_snap = 0, pops = 0;
    logic saw_full = 1'b0;
    logic [31:0] exp1 = '0, exp2 = '0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [31:0] rf_regs [32];

    rf_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rf_RegWrite(rf_RegWrite), .rf_A1(rf_A1), .rf_A2(rf_A2), .rf_A3(rf_A3), .rf_WD3(rf_WD3),
        .rf_RD1(rf_RD1), .rf_RD2(rf_RD2), .wbuf_count(wbuf_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Regfile: one slot per cycle, write or registered read.
    always @(posedge clk) begin
        if (rf_RegWrite) begin
            if (rf_A3 != 5'd0) rf_regs[rf_A3] <= rf_WD3;
        end else begin
            rf_RD1 <= rf_regs[rf_A1];
            rf_RD2 <= rf_regs[rf_A2];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Accepted read: queue the expected operands.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            exp_q.push_back({exp1, exp2});
            fire_cnt_snap = int'(wbuf_count);
        end
    end

    // Response monitor plus per-cycle write-side properties.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_data1", rsp_data1, mon_e[63:32]);
                    chk("rsp_data2", rsp_data2, mon_e[31:0]);
                end
            end
            chk("wr_ready_vs_full", {31'd0, wr_ready}, {31'd0, (wbuf_count != 3'(DEPTH))});
            if (wbuf_count == 3'(DEPTH)) saw_full = 1'b1;
            if (wbuf_count != 0 && !rf_RegWrite) nopop++;
            else nopop = 0;
            if (wbuf_count != 0) chk("pop_within_starve_bound", {31'd0, (nopop <= SL + 1)}, 32'd1);
        end
    end

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        wr_addr = a; wr_data = d; wr_valid = 1'b1;
        @(negedge clk);
        while (!wr_ready && n < 40) begin n++; @(negedge clk); end
        if (!wr_ready) chk("wr_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2);
        int n = 0;
        rd_addr1 = a1; rd_addr2 = a2; exp1 = e1; exp2 = e2; rd_valid = 1'b1;
        @(negedge clk);
        while (!rd_ready && n < 40) begin n++; @(negedge clk); end
        if (!rd_ready) chk("rd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rd_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((wbuf_count != 0 || exp_q.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("quiet_timeout", {31'd0, (n < 100)}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_regs[i] = '0;
        rf_regs[0] = 32'hDEAD_BEEF;  // junk in r0 must never reach a response

        // Reset values
        #12;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data1", rsp_data1, 32'd0);
        chk("rst_rsp_data2", rsp_data2, 32'd0);
        chk("rst_rf_A1", {27'd0, rf_A1}, 32'd0);
        chk("rst_rf_A2", {27'd0, rf_A2}, 32'd0);
        chk("rst_regwrite", {31'd0, rf_RegWrite}, 32'd0);
        chk("rst_wbuf_count", {29'd0, wbuf_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Write r5 then read (5,0); response two cycles after acceptance
        do_write(5'd5, 32'h1234);
        do_read(5'd5, 5'd0, 32'h1234, 32'd0);
        @(negedge clk);
        chk("latency_accept_plus1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("latency_accept_plus2", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;

        // Writes r1..r4 (repeated) under a continuous read stream of (0,0)
        wait_quiet();
        rd_addr1 = 5'd0; rd_addr2 = 5'd0; exp1 = '0; exp2 = '0; rd_valid = 1'b1;
        for (int k = 0; k < 12; k++) do_write(5'(1 + k % 4), 32'hA + 32'(k % 4));
        rd_valid = 1'b0;
`ifdef RF_ARB_FWD_EN
        chk("fifo_reached_full", {31'd0, saw_full}, 32'd1);
`endif
        wait_quiet();
        do_read(5'd1, 5'd4, 32'hA, 32'hD);
        do_read(5'd2, 5'd3, 32'hB, 32'hC);

        // r7=0x11, r7=0x22 then read (7,7)
        wait_quiet();
        rd_addr1 = 5'd0; rd_addr2 = 5'd0; exp1 = '0; exp2 = '0; rd_valid = 1'b1;
        do_write(5'd7, 32'h11);
        do_write(5'd7, 32'h22);
        do_read(5'd7, 5'd7, 32'h22, 32'h22);
`ifdef RF_ARB_FWD_EN
        chk("fwd_fifo_nonempty_at_accept", {31'd0, (fire_cnt_snap != 0)}, 32'd1);
`endif

        // Write pushed in the read's acceptance cycle is ordered after it
        wait_quiet();
        do_write(5'd8, 32'h55);
        fork
            do_write(5'd8, 32'h66);
`ifdef RF_ARB_FWD_EN
            do_read(5'd8, 5'd8, 32'h55, 32'h55);
`else
            do_read(5'd8, 5'd8, 32'h66, 32'h66);
`endif
        join
        wait_quiet();
        do_read(5'd8, 5'd8, 32'h66, 32'h66);

        // Write to r0 is discarded; r0 reads as zero
        wait_quiet();
        do_write(5'd0, 32'hFFFF);
        @(negedge clk);
        chk("r0_write_not_enqueued", {29'd0, wbuf_count}, 32'd0);
        @(posedge clk); #1;
        do_read(5'd0, 5'd0, 32'd0, 32'd0);
        do_read(5'd0, 5'd5, 32'd0, 32'h1234);

        // Response held 5 cycles with rsp_ready low
        wait_quiet();
        rsp_ready = 1'b0;
        do_read(5'd1, 5'd2, 32'hA, 32'hB);
        @(posedge clk); #1;
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = (i < 2);
            wr_addr  = (i == 0) ? 5'd9 : 5'd10;
            wr_data  = (i == 0) ? 32'h99 : 32'h100;
            rd_valid = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd4; exp1 = 32'hC; exp2 = 32'hD;
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_data1", rsp_data1, 32'hA);
            chk("hold_rsp_data2", rsp_data2, 32'hB);
            chk("hold_rd_ready", {31'd0, rd_ready}, 32'd0);
            if (rf_RegWrite) pops++;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        chk("hold_pops", 32'(pops), 32'd2);
        rsp_ready = 1'b1;
        do_read(5'd3, 5'd4, 32'hC, 32'hD);
        do_read(5'd9, 5'd10, 32'h99, 32'h100);

        // Reset while in CAPTURE with buffered writes
        wait_quiet();
        do_write(5'd20, 32'h2020);
        wr_addr = 5'd21; wr_data = 32'h2121; wr_valid = 1'b1;
        rd_addr1 = 5'd3; rd_addr2 = 5'd4; exp1 = 32'hC; exp2 = 32'hD; rd_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_valid = 1'b0;
        @(negedge clk);
`ifdef RF_ARB_FWD_EN
        chk("pre_reset_wbuf_count", {29'd0, wbuf_count}, 32'd2);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_wbuf_count", {29'd0, wbuf_count}, 32'd0);
        chk("midrst_regwrite", {31'd0, rf_RegWrite}, 32'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_regwrite", {31'd0, rf_RegWrite}, 32'd0);
            chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        do_read(5'd1, 5'd0, 32'hA, 32'd0);

        wait_quiet();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Sequencing controller for the MIPS `Regfile`. The register file has a single access slot per cycle: it either writes (`RegWrite=1`) or updates its registered read outputs (`RegWrite=0`), never both. This block sits between decode/operand-fetch, which issues read requests, and writeback, which issues write requests. It buffers writes in a small FIFO, arbitrates the slot, forwards pending write data to reads, and returns both operands through a valid/ready response.

## Interface
- `WBUF_DEPTH_LOG2`, default 2: write FIFO depth is 2^N entries.
- `STARVE_LIMIT`, default 4: maximum consecutive read-won slots while the FIFO is non-empty before a write is forced.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr_valid` input 1: write request.
- `wr_ready` output 1: write accepted on `wr_valid & wr_ready`.
- `wr_addr` input 5: destination register.
- `wr_data` input 32: write data.
- `rd_valid` input 1: read request.
- `rd_ready` output 1: read accepted on `rd_valid & rd_ready`.
- `rd_addr1` input 5: first operand register.
- `rd_addr2` input 5: second operand register.
- `rsp_valid` output 1: operand response valid.
- `rsp_ready` input 1: response consumed on `rsp_valid & rsp_ready`.
- `rsp_data1` output 32: first operand.
- `rsp_data2` output 32: second operand.
- `rf_RegWrite` output 1: drives `Regfile.RegWrite`.
- `rf_A1` output 5: drives `Regfile.A1`.
- `rf_A2` output 5: drives `Regfile.A2`.
- `rf_A3` output 5: drives `Regfile.A3`.
- `rf_WD3` output 32: drives `Regfile.WD3`.
- `rf_RD1` input 32: from `Regfile.RD1`.
- `rf_RD2` input 32: from `Regfile.RD2`.
- `wbuf_count` output WBUF_DEPTH_LOG2+1: current FIFO occupancy.

## Operation
- **Write path**
  - `wr_ready = !full`.
  - A write to `wr_addr==0` is accepted and discarded, never enqueued.
  - Push and pop may occur in the same cycle.
- **Slot arbitration** (combinational, each cycle)
  - `force_wr = full | (starve == STARVE_LIMIT)`.
  - A read wins the slot if the handshake fires.
  - Otherwise, if the FIFO is non-empty, the head is popped: `rf_RegWrite=1`, `rf_A3/rf_WD3` = head.
  - Otherwise the slot is idle (`rf_RegWrite=0`).
- **Read acceptance**
  - `rd_ready = (state==IDLE | (state==RESP & rsp_ready)) & !force_wr`.
  - When a read is accepted, `rf_A1/rf_A2` are driven from `rd_addr1/rd_addr2` with `rf_RegWrite=0`.
  - When no read is accepted, `rf_A1/rf_A2` hold their last read addresses.
- **Starve counter**
  - Increments when a read wins while the FIFO is non-empty.
  - Clears on every pop.
  - Saturates at STARVE_LIMIT.
- **Forwarding**
  - At read acceptance, each read address is compared against all valid FIFO entries.
  - The youngest matching entry's data is captured with a hit flag.
  - A write pushed in the same cycle as the read acceptance is ordered after the read and is not forwarded.
- **Register 0:** a read address of 0 always returns 0, regardless of `rf_RD*` or any forwarding hit.
- **States**
  - IDLE: no read outstanding.
  - CAPTURE: one cycle after acceptance. `rf_RD*` are valid; the slot is free for a pop. The response is `hit ? fwd : rf_RD`, loaded into the response registers. Next state is RESP.
  - RESP: `rsp_valid=1`. The response holds until `rsp_ready`. The next state is CAPTURE if a new read is accepted in the same cycle, otherwise IDLE.

## Timing
- Read latency: accept in cycle N, `rsp_valid` rises in cycle N+2.
- Sustained read throughput with `rsp_ready=1`: one read every 2 cycles.
- Write visibility: a popped write is in the register file after the pop edge. Reads accepted after the push see the data, via forwarding or directly.
- Reset (async, `rst_n=0`):
  - FIFO empty, `wbuf_count=0`, `starve=0`, state IDLE.
  - `rsp_valid=0`, `rsp_data1=0`, `rsp_data2=0`.
  - `rf_A1=0`, `rf_A2=0`, `rf_RegWrite=0`.
- Reset mid-operation drops the outstanding read and all buffered writes.

## Configuration
- `RF_ARB_FWD_EN` defined: forwarding as described above.
- `RF_ARB_FWD_EN` undefined:
  - No compare logic.
  - `rd_ready` is additionally gated by FIFO empty (drain-before-read).
  - `starve` is unused and tied to 0.

## Test plan
- Reset, write r5=0x1234 then, on the following cycle, read (5,0): `rsp_data1=0x1234`, `rsp_data2=0`, `rsp_valid` at accept+2.
- Push 4 writes r1..r4=0xA..0xD with `rd_valid` held high: `wr_ready=0` when full, and at least one pop occurs within STARVE_LIMIT+1 cycles.
- FWD_EN: push r7=0x11, then r7=0x22, then immediately read (7,7): both operands are 0x22, and the FIFO is still non-empty at acceptance.
- Write r0=0xFFFF, then read (0,0): the write is not enqueued (`wbuf_count` stays 0) and both operands are 0.
- Hold `rsp_ready=0` for 5 cycles: `rsp_data*` stable, `rd_ready=0`, buffered writes continue to pop.
- Assert `rst_n=0` while in CAPTURE with 2 buffered writes: `rsp_valid=0`, `wbuf_count=0` immediately, and no `rf_RegWrite` pulses afterward.
